// File: rtl/sd_spi_init_engine_pkg.sv
// Shared definitions for the SD-card SPI-mode initialisation engine:
// command indices, FSM state encoding, error codes, expected R1 values,
// and the single-bit CRC7 step used when SD_CRC7_EN is defined.
package sd_spi_init_engine_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POWERUP = 3'd1,
        ST_SEND    = 3'd2,
        ST_POLL_R1 = 3'd3,
        ST_TAIL    = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_BAD_R1  = 3'd2;
    localparam logic [2:0] ERR_ECHO    = 3'd3;
    localparam logic [2:0] ERR_ACMD41  = 3'd4;

    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h05;

    localparam logic [7:0]  CMD8_ECHO  = 8'hAA;
    localparam logic [3:0]  CMD8_VHS   = 4'h1;
    localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
    localparam logic [31:0] ACMD41_HCS = 32'h4000_0000;

    // Precomputed CRC bytes; only CMD0 and CMD8 need a valid CRC in SPI mode
    function automatic logic [7:0] fixed_crc(input logic [5:0] idx);
        if (idx == CMD0)      return 8'h95;
        else if (idx == CMD8) return 8'h87;
        else                  return 8'hFF;
    endfunction

    // One serial step of CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/sd_spi_byte_xfer.sv
// Full-duplex SPI mode-0 byte shifter. One byte takes 16*CLK_DIV clk cycles.
// Handshake: start is honoured only while idle (a start during a transfer is
// dropped); done pulses for one cycle when the byte is finished, and rx_byte
// holds the received byte from that cycle until the next start.
module sd_spi_byte_xfer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       spi_miso,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       spi_sck,
    output logic       spi_mosi
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active;
    logic [DW-1:0] div_cnt;
    logic [3:0]    half_cnt;
    logic [7:0]    tx_sh;

    // Half-period timer: even halves end with a rising edge (sample MISO),
    // odd halves end with a falling edge (advance MOSI)
    always_ff @(posedge clk) begin
        if (!rst) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= 4'd0;
            tx_sh    <= 8'hFF;
            rx_byte  <= 8'h00;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active   <= 1'b1;
                    div_cnt  <= '0;
                    half_cnt <= 4'd0;
                    spi_mosi <= tx_byte[7];
                    tx_sh    <= {tx_byte[6:0], 1'b1};
                end
            end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 4'd1;
                if (!half_cnt[0]) begin
                    spi_sck <= 1'b1;
                    rx_byte <= {rx_byte[6:0], spi_miso};
                end else begin
                    spi_sck <= 1'b0;
                    if (half_cnt == 4'd15) begin
                        active   <= 1'b0;
                        done     <= 1'b1;
                        spi_mosi <= 1'b1;
                    end else begin
                        spi_mosi <= tx_sh[7];
                        tx_sh    <= {tx_sh[6:0], 1'b1};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_spi_init_engine.sv
// SD-card SPI-mode initialisation sequencer: power-up clocks, CMD0, CMD8,
// CMD55/ACMD41 loop, CMD58 (v2 cards), CMD16 (byte-addressed cards).
// Optional macro SD_CRC7_EN: generate the command CRC7 serially instead of
// using fixed CRC bytes. state_dbg exposes the FSM state for observation.
import sd_spi_init_engine_pkg::*;

module sd_spi_init_engine #(
    parameter int CLK_DIV        = 4,
    parameter int INIT_CLKS      = 80,
    parameter int NCR_MAX        = 8,
    parameter int ACMD41_RETRIES = 1000,
    parameter int BLOCK_LEN      = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       spi_miso,
    output logic       spi_mosi,
    output logic       spi_sck,
    output logic       spi_cs,
    output logic       busy,
    output logic       ready,
    output logic       error,
    output logic [2:0] err_code,
    output logic       sdhc,
    output logic [7:0] r1_last,
    output logic [2:0] state_dbg
);

    localparam int PU_BYTES = (INIT_CLKS + 7) / 8;
    localparam int RW       = $clog2(ACMD41_RETRIES + 1);
    localparam int CW       = 16;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    cmd, cmd_n;
    logic [RW-1:0] retry, retry_n, retry_inc;
    logic          v2, v2_n, in_flight, in_flight_n, cs_n;
    logic          ready_n, error_n, sdhc_n;
    logic [2:0]    err_n;
    logic [7:0]    r1_n;
    logic          ocr_hcs, ocr_hcs_n;
    logic [3:0]    vhs, vhs_n;
    logic [7:0]    echo, echo_n;
    logic          go_cmd, go_err;
    logic [5:0]    next_cmd;
    logic [2:0]    err_sel;
    logic          x_start, x_done;
    logic [7:0]    x_tx, x_rx, frame_byte, crc_byte;
    logic [31:0]   cmd_arg;

    sd_spi_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk      (clk),
        .rst      (rst),
        .start    (x_start),
        .tx_byte  (x_tx),
        .spi_miso (spi_miso),
        .done     (x_done),
        .rx_byte  (x_rx),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi)
    );

    assign busy      = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign state_dbg = state;

    // Argument of the command currently being framed
    always_comb begin
        cmd_arg = 32'h0;
        if (cmd == CMD8)             cmd_arg = CMD8_ARG;
        else if (cmd == ACMD41 && v2) cmd_arg = ACMD41_HCS;
        else if (cmd == CMD16)       cmd_arg = 32'(BLOCK_LEN);
    end

    // Byte k of the SEND phase: 0xFF lead-in (CS already low), then 6 frame bytes
    always_comb begin
        case (cnt[2:0])
            3'd1:    frame_byte = {2'b01, cmd};
            3'd2:    frame_byte = cmd_arg[31:24];
            3'd3:    frame_byte = cmd_arg[23:16];
            3'd4:    frame_byte = cmd_arg[15:8];
            3'd5:    frame_byte = cmd_arg[7:0];
            3'd6:    frame_byte = crc_byte;
            default: frame_byte = 8'hFF;
        endcase
    end

`ifdef SD_CRC7_EN
    logic [6:0] crc;
    logic [7:0] crc_sh;
    logic [3:0] crc_bits;

    // CRC7 over frame bytes 1..5, one bit per clk while each byte is on the wire
    always_ff @(posedge clk) begin
        if (!rst) begin
            crc      <= 7'h0;
            crc_sh   <= 8'h0;
            crc_bits <= 4'd0;
        end else if (state == ST_SEND && x_start) begin
            if (cnt == CW'(0)) crc <= 7'h0;
            if (cnt >= CW'(1) && cnt <= CW'(5)) begin
                crc_sh   <= x_tx;
                crc_bits <= 4'd8;
            end
        end else if (crc_bits != 4'd0) begin
            crc      <= crc7_step(crc, crc_sh[7]);
            crc_sh   <= {crc_sh[6:0], 1'b0};
            crc_bits <= crc_bits - 4'd1;
        end
    end

    assign crc_byte = {crc, 1'b1};
`else
    assign crc_byte = fixed_crc(cmd);
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd       <= CMD0;
            retry     <= '0;
            v2        <= 1'b0;
            in_flight <= 1'b0;
            spi_cs    <= 1'b1;
            ready     <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            sdhc      <= 1'b0;
            r1_last   <= 8'hFF;
            ocr_hcs   <= 1'b0;
            vhs       <= 4'h0;
            echo      <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd       <= cmd_n;
            retry     <= retry_n;
            v2        <= v2_n;
            in_flight <= in_flight_n;
            spi_cs    <= cs_n;
            ready     <= ready_n;
            error     <= error_n;
            err_code  <= err_n;
            sdhc      <= sdhc_n;
            r1_last   <= r1_n;
            ocr_hcs   <= ocr_hcs_n;
            vhs       <= vhs_n;
            echo      <= echo_n;
        end
    end

    // Next-state logic: one byte launched whenever a byte state has none in flight
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cmd_n       = cmd;
        retry_n     = retry;
        v2_n        = v2;
        in_flight_n = in_flight;
        cs_n        = spi_cs;
        ready_n     = ready;
        error_n     = error;
        err_n       = err_code;
        sdhc_n      = sdhc;
        r1_n        = r1_last;
        ocr_hcs_n   = ocr_hcs;
        vhs_n       = vhs;
        echo_n      = echo;
        go_cmd      = 1'b0;
        next_cmd    = cmd;
        go_err      = 1'b0;
        err_sel     = ERR_NONE;
        x_start     = 1'b0;
        x_tx        = 8'hFF;
        retry_inc   = (retry == RW'(ACMD41_RETRIES)) ? retry : retry + 1'b1;

        if (x_done) in_flight_n = 1'b0;
        if (busy && !in_flight) begin
            x_start     = 1'b1;
            in_flight_n = 1'b1;
            if (state == ST_SEND) x_tx = frame_byte;
        end

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n = ST_POWERUP;
                    cnt_n   = '0;
                    retry_n = '0;
                    v2_n    = 1'b0;
                    cs_n    = 1'b1;
                    ready_n = 1'b0;
                    error_n = 1'b0;
                    err_n   = ERR_NONE;
                    sdhc_n  = 1'b0;
                end
            end
            ST_POWERUP: begin
                if (x_done) begin
                    if (cnt == CW'(PU_BYTES - 1)) begin
                        go_cmd   = 1'b1;
                        next_cmd = CMD0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (x_done) begin
                    if (cnt == CW'(6)) begin
                        state_n = ST_POLL_R1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_POLL_R1: begin
                if (x_done) begin
                    if (!x_rx[7]) begin
                        r1_n  = x_rx;
                        cnt_n = '0;
                        if (cmd == CMD8 || cmd == CMD58) begin
                            state_n = ST_TAIL;
                        end else begin
                            state_n = ST_CHECK;
                            cs_n    = 1'b1;
                        end
                    end else if (cnt == CW'(NCR_MAX - 1)) begin
                        go_err  = 1'b1;
                        err_sel = ERR_TIMEOUT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (x_done) begin
                    if (cnt == CW'(0)) ocr_hcs_n = x_rx[6];
                    if (cnt == CW'(2)) vhs_n = x_rx[3:0];
                    if (cnt == CW'(3)) begin
                        echo_n  = x_rx;
                        state_n = ST_CHECK;
                        cs_n    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (x_done) begin
                    case (cmd)
                        CMD0: begin
                            if (r1_last == R1_IDLE) begin go_cmd = 1'b1; next_cmd = CMD8; end
                            else begin go_err = 1'b1; err_sel = ERR_BAD_R1; end
                        end
                        CMD8: begin
                            if (r1_last == R1_IDLE) begin
                                if (echo == CMD8_ECHO && vhs == CMD8_VHS) begin
                                    v2_n = 1'b1; go_cmd = 1'b1; next_cmd = CMD55;
                                end else begin
                                    go_err = 1'b1; err_sel = ERR_ECHO;
                                end
                            end else if (r1_last == R1_ILLEGAL) begin
                                v2_n = 1'b0; go_cmd = 1'b1; next_cmd = CMD55;
                            end else begin
                                go_err = 1'b1; err_sel = ERR_BAD_R1;
                            end
                        end
                        CMD55: begin
                            if (r1_last[7:1] == 7'h0) begin go_cmd = 1'b1; next_cmd = ACMD41; end
                            else begin go_err = 1'b1; err_sel = ERR_BAD_R1; end
                        end
                        ACMD41: begin
                            if (r1_last == R1_READY) begin
                                go_cmd = 1'b1;
                                if (v2) next_cmd = CMD58;
                                else begin sdhc_n = 1'b0; next_cmd = CMD16; end
                            end else if (r1_last == R1_IDLE) begin
                                retry_n = retry_inc;
                                if (retry_inc == RW'(ACMD41_RETRIES)) begin
                                    go_err = 1'b1; err_sel = ERR_ACMD41;
                                end else begin
                                    go_cmd = 1'b1; next_cmd = CMD55;
                                end
                            end else begin
                                go_err = 1'b1; err_sel = ERR_BAD_R1;
                            end
                        end
                        CMD58: begin
                            if (r1_last == R1_READY) begin
                                sdhc_n = ocr_hcs;
                                if (ocr_hcs) begin state_n = ST_DONE; ready_n = 1'b1; end
                                else begin go_cmd = 1'b1; next_cmd = CMD16; end
                            end else begin
                                go_err = 1'b1; err_sel = ERR_BAD_R1;
                            end
                        end
                        CMD16: begin
                            if (r1_last == R1_READY) begin state_n = ST_DONE; ready_n = 1'b1; end
                            else begin go_err = 1'b1; err_sel = ERR_BAD_R1; end
                        end
                        default: begin go_err = 1'b1; err_sel = ERR_BAD_R1; end
                    endcase
                end
            end
            default: ;
        endcase

        if (go_cmd) begin
            state_n = ST_SEND;
            cnt_n   = '0;
            cs_n    = 1'b0;
            cmd_n   = next_cmd;
        end
        if (go_err) begin
            state_n = ST_ERR;
            cs_n    = 1'b1;
            error_n = 1'b1;
            err_n   = err_sel;
        end
    end

endmodule

// File: tb/tb_sd_spi_init_engine.sv
// Bench for sd_spi_init_engine: behavioural SD card on the SPI pins,
// expected command frames queued per scenario and compared as they arrive.
`timescale 1ns/1ps
module tb_sd_spi_init_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       spi_miso = 1'b1;
    logic       spi_mosi, spi_sck, spi_cs, busy, ready, error, sdhc;
    logic [2:0] err_code, state_dbg;
    logic [7:0] r1_last;

    int checks = 0;
    int errors = 0;

    sd_spi_init_engine #(.ACMD41_RETRIES(5)) dut (
        .clk(clk), .rst(rst), .start(start), .spi_miso(spi_miso),
        .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_cs(spi_cs),
        .busy(busy), .ready(ready), .error(error), .err_code(err_code),
        .sdhc(sdhc), .r1_last(r1_last), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard and card configuration ----------------
    logic [47:0] exp_q[$];
    logic [7:0]  rsp_q[$];
    logic [7:0]  cfg_cmd8_r1 = 8'h01;
    logic [7:0]  cfg_echo = 8'hAA;
    logic [31:0] cfg_ocr = 32'hC0FF8000;
    logic        cfg_stuck = 1'b0;
    int          acmd_busy_left = 0;

    // ---------------- card model state ----------------
    int          bit_cnt = 0;
    int          fidx = 0;
    logic        frame_done = 1'b0;
    logic [47:0] frame = '0;
    logic [7:0]  rx_sh = 8'hFF;
    logic [7:0]  out_sh = 8'hFF;
    logic [7:0]  out_b;
    logic [5:0]  cur_cmd = 6'h3F;
    int          post_bytes = 0;
    int          n_cmd55 = 0;
    int          pu_clks = 0;
    logic        seen_cs_low = 1'b0;

`ifdef SD_CRC7_EN
    function automatic logic [7:0] crc7_ref(input logic [39:0] d);
        logic [6:0] c;
        logic fb;
        c = 7'h0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return {c, 1'b1};
    endfunction
`endif

    function automatic logic [7:0] exp_crc(input logic [5:0] idx, input logic [31:0] arg);
        if (idx == 6'd0) return 8'h95;
        if (idx == 6'd8) return 8'h87;
`ifdef SD_CRC7_EN
        if (idx == 6'd55 && arg == 32'h0) return 8'h65;
        return crc7_ref({2'b01, idx, arg});
`else
        return 8'hFF;
`endif
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, exp_crc(idx, arg)};
    endfunction

    task automatic push_rsp(input logic [7:0] b);
        rsp_q.push_back(b);
    endtask

    // Card reply for a completed frame (one 0xFF of Ncr before each R1)
    task automatic card_respond(input logic [5:0] idx);
        if (cfg_stuck) return;
        push_rsp(8'hFF);
        case (idx)
            6'd0:  push_rsp(8'h01);
            6'd8: begin
                push_rsp(cfg_cmd8_r1);
                if (cfg_cmd8_r1 == 8'h01) begin
                    push_rsp(8'h00); push_rsp(8'h00); push_rsp(8'h01); push_rsp(cfg_echo);
                end
            end
            6'd55: push_rsp(8'h01);
            6'd41: begin
                if (acmd_busy_left > 0) begin acmd_busy_left--; push_rsp(8'h01); end
                else push_rsp(8'h00);
            end
            6'd58: begin
                push_rsp(8'h00);
                push_rsp(cfg_ocr[31:24]); push_rsp(cfg_ocr[23:16]);
                push_rsp(cfg_ocr[15:8]);  push_rsp(cfg_ocr[7:0]);
            end
            6'd16: push_rsp(8'h00);
            default: push_rsp(8'h04);
        endcase
    endtask

    // Received-byte handler: frame assembly and scoreboard comparison
    task automatic card_rx_byte(input logic [7:0] b);
        logic [47:0] e;
        if (frame_done) begin
            post_bytes++;
        end else if (fidx == 0) begin
            if (b[7:6] == 2'b01) begin
                frame = {40'h0, b};
                cur_cmd = b[5:0];
                fidx = 1;
            end
        end else begin
            frame = {frame[39:0], b};
            fidx++;
            if (fidx == 6) begin
                frame_done = 1'b1;
                post_bytes = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame got %h required none", frame);
                end else begin
                    e = exp_q.pop_front();
                    if (frame !== e) begin
                        errors++;
                        $display("FAIL frame got %h required %h", frame, e);
                    end
                end
                if (frame[45:40] == 6'd55) n_cmd55++;
                card_respond(frame[45:40]);
            end
        end
    endtask

    // SPI mode-0 slave: sample on rising SCK, drive MISO on falling SCK
    always @(posedge spi_sck or negedge spi_sck or posedge spi_cs) begin
        if (spi_cs) begin
            bit_cnt = 0; fidx = 0; frame_done = 1'b0;
            spi_miso = 1'b1; out_sh = 8'hFF;
            rsp_q.delete();
        end else if (spi_sck) begin
            rx_sh = {rx_sh[6:0], spi_mosi};
            bit_cnt++;
        end else if (bit_cnt == 8) begin
            bit_cnt = 0;
            card_rx_byte(rx_sh);
            out_b = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
            spi_miso = out_b[7];
            out_sh = {out_b[6:0], 1'b1};
        end else begin
            spi_miso = out_sh[7];
            out_sh = {out_sh[6:0], 1'b1};
        end
    end

    // Power-up clock counter: SCK rising edges with CS high before first CS low
    always @(posedge spi_sck) if (spi_cs && !seen_cs_low) pu_clks++;
    always @(negedge spi_cs) seen_cs_low = 1'b1;

    // ---------------- driver tasks ----------------
    task automatic prep(input logic [7:0] c8r1, input logic [7:0] echo, input int abusy, input logic stuck);
        exp_q.delete();
        cfg_cmd8_r1 = c8r1; cfg_echo = echo; acmd_busy_left = abusy; cfg_stuck = stuck;
        n_cmd55 = 0; post_bytes = 0; pu_clks = 0; seen_cs_low = 1'b0; cur_cmd = 6'h3F;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60000) begin @(negedge clk); n++; end
        checks++;
        if (busy) begin errors++; $display("FAIL %s_timeout busy=%b required 0", name, busy); end
    endtask

    task automatic push_v2_seq(input int pairs);
        exp_q.push_back(mk(6'd0, 32'h0));
        exp_q.push_back(mk(6'd8, 32'h1AA));
        for (int i = 0; i < pairs; i++) begin
            exp_q.push_back(mk(6'd55, 32'h0));
            exp_q.push_back(mk(6'd41, 32'h40000000));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (spi_cs !== 1'b1)   begin errors++; $display("FAIL rst_cs got %b required 1", spi_cs); end
        checks++; if (spi_sck !== 1'b0)  begin errors++; $display("FAIL rst_sck got %b required 0", spi_sck); end
        checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi got %b required 1", spi_mosi); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        checks++; if (ready !== 1'b0 || error !== 1'b0 || sdhc !== 1'b0)
            begin errors++; $display("FAIL rst_flags got %b%b%b required 000", ready, error, sdhc); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_err_code got %0d required 0", err_code); end
        checks++; if (r1_last !== 8'hFF) begin errors++; $display("FAIL rst_r1_last got %h required ff", r1_last); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got %0d required 0", state_dbg); end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || spi_cs !== 1'b1)
            begin errors++; $display("FAIL idle_hold busy=%b cs=%b required 0 1", busy, spi_cs); end
    endtask

    task automatic test_v2_sdhc(input string name);
        prep(8'h01, 8'hAA, 3, 1'b0);
        push_v2_seq(4);
        exp_q.push_back(mk(6'd58, 32'h0));
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        wait_idle(name);
        checks++; if (ready !== 1'b1 || error !== 1'b0)
            begin errors++; $display("FAIL %s_ready ready=%b error=%b required 1 0", name, ready, error); end
        checks++; if (sdhc !== 1'b1) begin errors++; $display("FAIL %s_sdhc got %b required 1", name, sdhc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_frames_left got %0d required 0", name, exp_q.size()); end
        checks++; if (n_cmd55 != 4) begin errors++; $display("FAIL %s_pairs got %0d required 4", name, n_cmd55); end
        checks++; if (pu_clks != 80) begin errors++; $display("FAIL %s_powerup_clks got %0d required 80", name, pu_clks); end
        checks++; if (r1_last !== 8'h00) begin errors++; $display("FAIL %s_r1_last got %h required 00", name, r1_last); end
        checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL %s_cs got %b required 1", name, spi_cs); end
    endtask

    task automatic test_v1_restart();
        prep(8'h05, 8'hAA, 0, 1'b0);
        exp_q.push_back(mk(6'd0, 32'h0));
        exp_q.push_back(mk(6'd8, 32'h1AA));
        exp_q.push_back(mk(6'd55, 32'h0));
        exp_q.push_back(mk(6'd41, 32'h0));
        exp_q.push_back(mk(6'd16, 32'h200));
        pulse_start();
        checks++; if (ready !== 1'b0 || busy !== 1'b1 || sdhc !== 1'b0)
            begin errors++; $display("FAIL restart_clear ready=%b busy=%b sdhc=%b required 0 1 0", ready, busy, sdhc); end
        wait_idle("v1");
        checks++; if (ready !== 1'b1 || sdhc !== 1'b0)
            begin errors++; $display("FAIL v1_result ready=%b sdhc=%b required 1 0", ready, sdhc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL v1_frames_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_stuck();
        prep(8'h01, 8'hAA, 0, 1'b1);
        exp_q.push_back(mk(6'd0, 32'h0));
        pulse_start();
        wait_idle("stuck");
        checks++; if (error !== 1'b1 || err_code !== 3'd1 || ready !== 1'b0)
            begin errors++; $display("FAIL stuck_err error=%b code=%0d ready=%b required 1 1 0", error, err_code, ready); end
        checks++; if (post_bytes != 8) begin errors++; $display("FAIL stuck_poll_bytes got %0d required 8", post_bytes); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stuck_frames_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_cmd8_echo();
        prep(8'h01, 8'h55, 0, 1'b0);
        exp_q.push_back(mk(6'd0, 32'h0));
        exp_q.push_back(mk(6'd8, 32'h1AA));
        pulse_start();
        wait_idle("echo");
        checks++; if (error !== 1'b1 || err_code !== 3'd3)
            begin errors++; $display("FAIL echo_err error=%b code=%0d required 1 3", error, err_code); end
        checks++; if (r1_last !== 8'h01) begin errors++; $display("FAIL echo_r1_last got %h required 01", r1_last); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL echo_frames_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_acmd41_timeout();
        prep(8'h01, 8'hAA, 1000, 1'b0);
        push_v2_seq(5);
        pulse_start();
        wait_idle("acmd41");
        checks++; if (error !== 1'b1 || err_code !== 3'd4)
            begin errors++; $display("FAIL acmd41_err error=%b code=%0d required 1 4", error, err_code); end
        checks++; if (n_cmd55 != 5) begin errors++; $display("FAIL acmd41_pairs got %0d required 5", n_cmd55); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL acmd41_frames_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_cmd();
        int n = 0;
        prep(8'h01, 8'hAA, 3, 1'b0);
        exp_q.push_back(mk(6'd0, 32'h0));
        pulse_start();
        while (!(cur_cmd == 6'd8 && fidx == 3 && !spi_cs) && n < 40000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 40000) begin errors++; $display("FAIL mid_reach_cmd8 cycles=%0d required <40000", n); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (spi_cs !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL mid_rst cs=%b sck=%b busy=%b required 1 0 0", spi_cs, spi_sck, busy); end
        checks++; if (spi_mosi !== 1'b1 || state_dbg !== 3'd0 || r1_last !== 8'hFF)
            begin errors++; $display("FAIL mid_rst_state mosi=%b state=%0d r1=%h required 1 0 ff", spi_mosi, state_dbg, r1_last); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_frames_left got %0d required 0", exp_q.size()); end
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        test_v2_sdhc("after_rst");
    endtask

    initial begin
        test_reset();
        test_v2_sdhc("v2");
        test_v1_restart();
        test_stuck();
        test_cmd8_echo();
        test_acmd41_timeout();
        test_reset_mid_cmd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_spi_init_engine.md
SD_SPI_INIT_ENGINE -- requirements
Module: sd_spi_init_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCK half-period (>=2).
REQ-002 SHALL have parameter INIT_CLKS, default 80, meaning SCK cycles sent with CS high at power-up (>=74).
REQ-003 SHALL have parameter NCR_MAX, default 8, meaning max 0xFF polling bytes before R1.
REQ-004 SHALL have parameter ACMD41_RETRIES, default 1000, meaning max CMD55/ACMD41 pairs.
REQ-005 SHALL have parameter BLOCK_LEN, default 512, meaning CMD16 argument.
REQ-006 SHALL have ports: clk input 1 system clock; rst input 1 reset, synchronous, active-low; start input 1 one-cycle init request; spi_miso input 1 card data out.
REQ-007 SHALL have ports: spi_mosi output 1; spi_sck output 1; spi_cs output 1 active-low.
REQ-008 SHALL have ports: busy output 1; ready output 1 card initialised; error output 1; err_code output 3; sdhc output 1 high-capacity card; r1_last output 8 last R1 received.

Function
REQ-009 SHALL use SPI mode 0: SCK idles low, MOSI changes on SCK falling edge, MISO sampled on SCK rising edge, MSB first; one byte = 16*CLK_DIV clk cycles.
REQ-010 SHALL frame every command as 6 bytes: 0x40|index, 32-bit argument MSB first, CRC byte; CS asserted low one byte before the frame and released after the response, followed by one 0xFF byte with CS high.
REQ-011 SHALL transmit 0xFF on MOSI whenever it is reading.
REQ-012 SHALL implement states IDLE, POWERUP, SEND, POLL_R1, TAIL, CHECK, DONE, ERR.
REQ-013 IDLE->POWERUP on start; POWERUP clocks INIT_CLKS SCK cycles with CS=1, MOSI=1, then issues CMD0.
REQ-014 POLL_R1 SHALL read bytes until bit7==0; after NCR_MAX bytes of 0xFF it SHALL go to ERR with err_code=1.
REQ-015 TAIL SHALL read 4 extra bytes for CMD8 (R7) and CMD58 (R3); 0 otherwise.
REQ-016 Sequence: CMD0 arg 0, expect R1=0x01; else err_code=2.
REQ-017 CMD8 arg 0x000001AA: R1=0x01 with echo byte 0xAA and voltage nibble 0x1 -> v2 card; R1=0x05 -> v1 card; echo mismatch -> err_code=3; other R1 -> err_code=2.
REQ-018 CMD55 arg 0 then ACMD41 (index 41) arg 0x40000000 (v2) or 0 (v1); repeat the pair while R1=0x01; on R1=0x00 proceed; after ACMD41_RETRIES pairs -> err_code=4.
REQ-019 v2 cards SHALL issue CMD58; sdhc = OCR bit 30; v1 cards SHALL set sdhc=0 without CMD58.
REQ-020 If sdhc=0, SHALL issue CMD16 arg BLOCK_LEN expecting R1=0x00, else err_code=2; if sdhc=1, skip CMD16.
REQ-021 DONE: ready=1, busy=0, CS=1; ERR: error=1, busy=0, CS=1; both hold until start or reset.
REQ-022 start while busy=1 SHALL be ignored; start in DONE/ERR SHALL clear ready, error, err_code, sdhc and restart at POWERUP.
REQ-023 busy SHALL be 1 in all states except IDLE, DONE, ERR; r1_last updates at the end of each POLL_R1 success.
REQ-024 Retry counter SHALL saturate and never wrap; width = $clog2(ACMD41_RETRIES+1).

Reset
REQ-025 On rst=0 at a clk edge, next cycle: state IDLE, spi_cs=1, spi_sck=0, spi_mosi=1, busy=0, ready=0, error=0, err_code=0, sdhc=0, r1_last=0xFF, all counters 0, including mid-byte.

Configuration
REQ-026 With SD_CRC7_EN defined, the CRC byte SHALL be CRC7 (poly x^7+x^3+1) over the first 5 bytes, shifted left with end bit 1, computed serially during transmission.
REQ-027 Without SD_CRC7_EN, CRC byte SHALL be 0x95 for CMD0, 0x87 for CMD8, 0xFF for all others.

Structure
REQ-028 Shared package SHALL hold command index constants (0, 8, 16, 41, 55, 58), state encoding, err_code values, and R1 expected-value constants.
REQ-029 Sub-module sd_spi_byte_xfer SHALL perform one full-duplex byte (start/done handshake, CLK_DIV parameter); the engine owns CS.

Verification
REQ-030 Card model v2 SDHC (R1 0x01, R7 0x000001AA, ACMD41 0x01 x3 then 0x00, OCR 0xC0FF8000) -> ready=1, sdhc=1, no CMD16 frame, 4 CMD55/ACMD41 pairs.
REQ-031 v1 card (CMD8 R1=0x05, ACMD41 0x00) -> no CMD58, CMD16 frame 0x50 00 00 02 00 xx, ready=1, sdhc=0.
REQ-032 MISO stuck 0xFF -> after CMD0 and 8 polling bytes, error=1, err_code=1.
REQ-033 CMD8 echo 0x55 -> err_code=3; ACMD41 always 0x01 with ACMD41_RETRIES=5 -> err_code=4 after exactly 5 pairs.
REQ-034 rst=0 during CMD8 byte 3 -> next cycle CS=1, SCK=0, busy=0; subsequent start re-runs POWERUP with 80 SCK cycles.
REQ-035 With SD_CRC7_EN, CMD0 and CMD8 CRC bytes equal 0x95 and 0x87; CMD55 arg 0 CRC byte equals 0x65.
